// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and helpers for the binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble digit correction, add 3 to any digit of 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_in,
    output logic [BCD_DIGIT_W-1:0] d_out
);

    always_comb d_out = (d_in >= BCD_DIGIT_W'(5)) ? d_in + BCD_DIGIT_W'(3) : d_in;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// binary_to_bcd_converter: sequential double-dabble, one bit per clock, with a saturating overflow flag.
module binary_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 24,
    parameter int DIGITS    = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [BIN_WIDTH-1:0]         binary_in,
    output logic                         ready,
    output logic                         done,
    output logic                         overflow,
    output logic [BCD_DIGIT_W*DIGITS-1:0] BCD_code
);

    localparam int          WW      = BCD_DIGIT_W * DIGITS;
    localparam int          CW      = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam logic [WW-1:0] SAT   = {DIGITS{4'h9}};

    bcd_state_t           state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [WW-1:0]        work_q, work_d, adj;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic [WW-1:0]        bcd_q, bcd_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d_in  (work_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .d_out (adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        case (state_q)
            IDLE: if (start) begin
                shift_d    = binary_in;
                work_d     = '0;
                cnt_d      = CW'(BIN_WIDTH);
                ovf_pend_d = 64'(binary_in) > MAX_VAL;
                ready_d    = 1'b0;
                state_d    = CONVERT;
            end
            CONVERT: begin
                // Top-digit carry is dropped; it only occurs for saturated inputs.
                work_d  = {adj[WW-2:0], shift_q[BIN_WIDTH-1]};
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    overflow_d = ovf_pend_q;
                    bcd_d      = ovf_pend_q ? SAT : work_d;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign BCD_code = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// tb_binary_to_bcd_converter: directed and random conversions checked against an arithmetic decimal model.
module tb_binary_to_bcd_converter;

    localparam int BW  = 24;
    localparam int DG  = 7;
    localparam longint MAXV = 64'd9999999;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] binary_in = '0;
    logic          ready, done, overflow;
    logic [4*DG-1:0] BCD_code;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [4*DG-1:0] prev_bcd = '0;
    logic            prev_ovf = 1'b0;

    binary_to_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .binary_in (binary_in),
        .ready     (ready),
        .done      (done),
        .overflow  (overflow),
        .BCD_code  (BCD_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*DG-1:0] ref_bcd(input longint v);
        logic [4*DG-1:0] r;
        longint x;
        r = '0;
        x = v;
        if (v > MAXV) return {DG{4'h9}};
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input logic [BW-1:0] v);
        int lat;
        logic ready_seen, hold_ok;
        lat = 0;
        ready_seen = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 60 && !ready; i++) tick();
        chk("ready_before_start", ready, 1);
        start = 1'b1;
        binary_in = v;
        tick();
        start = 1'b0;
        binary_in = BW'($urandom);
        while (!done && lat < 40) begin
            if (ready) ready_seen = 1'b1;
            if (BCD_code !== prev_bcd || overflow !== prev_ovf) hold_ok = 1'b0;
            tick();
            lat++;
        end
        chk("latency", lat, BW);
        chk("ready_low_while_busy", ready_seen, 0);
        chk("outputs_held", hold_ok, 1);
        chk("bcd", BCD_code, ref_bcd(longint'(v)));
        chk("overflow", overflow, longint'(v) > MAXV);
        prev_bcd = ref_bcd(longint'(v));
        prev_ovf = longint'(v) > MAXV;
        tick();
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", ready, 1);
    endtask

    initial begin
        int ndone, t1, t2;
        logic [BW-1:0] rv;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bcd", BCD_code, 0);

        conv(24'd0);
        conv(24'd1234);
        conv(24'd9999999);
        conv(24'd10000000);
        conv(24'd16777215);
        for (int n = 0; n < 12; n++) begin
            rv = (n % 3 == 0) ? BW'($urandom) : BW'($urandom_range(0, 9999999));
            conv(rv);
        end

        // start pulsed mid-conversion must be ignored
        start = 1'b1;
        binary_in = 24'd42;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i < 40; i++) begin
            if (i == 4) begin start = 1'b1; binary_in = 24'd777; end
            if (i == 5) start = 1'b0;
            if (done) begin
                ndone++;
                chk("ignored_start_bcd", BCD_code, 28'h0000042);
            end
            tick();
        end
        chk("ignored_start_done_count", ndone, 1);

        // reset mid-conversion aborts with no done pulse
        start = 1'b1;
        binary_in = 24'd555;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_bcd", BCD_code, 0);
        chk("midrst_done", done, 0);
        chk("midrst_overflow", overflow, 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("midrst_no_done", ndone, 0);
        prev_bcd = '0;
        prev_ovf = 1'b0;
        conv(24'd8);

        // start held high: back-to-back conversions
        start = 1'b1;
        binary_in = 24'd100;
        tick();
        binary_in = 24'd65535;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 80 && t2 < 0; i++) begin
            if (done && t1 < 0) begin
                t1 = cyc;
                chk("b2b_first_bcd", BCD_code, 28'h0000100);
            end else if (done) begin
                t2 = cyc;
                start = 1'b0;
                chk("b2b_second_bcd", BCD_code, 28'h0065535);
            end
            tick();
        end
        chk("b2b_spacing", t2 - t1, BW + 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
